lfsr_checker: RTL and testbench
===============================

# lfsr_checker

Receive-side companion to the team's N-bit LFSR pattern generator. It accepts the generator's parallel state word, self-synchronises to the sequence, predicts every following word, and flags and counts mismatches. It sits at the far end of a link or datapath under test, so a generator/checker pair gives built-in error checking for that path.

## Interface
- Width, 5: LFSR word width (≥3).
- Taps, 5'b10010: tap mask, identical to the generator's; bit Width-1 is unused.
- SyncCount, 3: consecutive correct predictions needed to declare lock (≥1).
- LossCount, 4: consecutive mispredictions while locked that drop lock (≥1).
- CntWidth, 8: error counter width.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low.
- In_Valid  input  1  In_Data carries a sequence word this cycle.
- In_Data  input  Width  received LFSR word.
- Locked  output  1  checker is synchronised.
- Error  output  1  one-cycle pulse per mispredicted word while locked.
- Err_Count  output  CntWidth  saturating count of locked-state errors.

## Operation
- Next-state function nxt(S), matching the generator:
  - Z = (S[Width-2:0] == 0); F = S[Width-1] ^ Z.
  - nxt[0] = F.
  - nxt[n] = S[n-1] ^ (Taps[n-1] & F) for n = 1..Width-1.
- Reference sequence for the defaults: 0, 5, 10, 20, 13, 26, 17, …
- Registers: state (HUNT/SYNC/LOCKED), Expect[Width], match_cnt, miss_cnt, Err_Count.
- HUNT: on a valid word, set Expect ← nxt(In_Data), match_cnt ← 0, and move to SYNC.
- SYNC: on a valid word:
  - Match (In_Data == Expect): match_cnt+1 and Expect ← nxt(In_Data). When the incremented match_cnt equals SyncCount, move to LOCKED and set miss_cnt ← 0.
  - Mismatch: reseed with Expect ← nxt(In_Data) and match_cnt ← 0, then stay in SYNC. No Error and no count.
- LOCKED: on every valid word, Expect ← nxt(Expect). Prediction free-runs and never follows the input.
  - Match: miss_cnt ← 0.
  - Mismatch: Error = 1 next cycle, Err_Count+1 (saturates at all-ones), miss_cnt+1. When the incremented miss_cnt equals LossCount, move to HUNT.
- In_Valid = 0: all registers hold and Error = 0; In_Data is ignored.
- Err_Count counts only while LOCKED. It clears only on Reset and survives lock loss.
- The all-zero word is a legal sequence member and gets no special treatment.

## Timing
- Reset asserted: state HUNT, Expect 0, counters 0, Locked 0, Error 0, Err_Count 0, all immediately. Reset mid-operation abandons lock with no error pulse.
- All outputs are registered.
  - Locked rises the cycle after the valid word that completes SyncCount matches.
  - Locked falls the cycle after the LossCount-th consecutive miss.
- Error and the Err_Count increment appear the cycle after the offending valid word.
- Throughput is one word per cycle with no back-pressure. Idle cycles between valid words are allowed and do not count toward any threshold.
- In the cycle Locked falls, that word still produces its Error and is counted. The next valid word reseeds in HUNT.

## Structure
- Shared package `lfsr_pkg`:
  - tap constants (TAP5 = 5'b10010, plus future widths);
  - checker state encoding;
  - a pure function implementing nxt(S) for the generator and the checker alike.
- One natural sub-module, `lfsr_next`: combinational nxt(S), parameterised by Width and Taps. The checker instantiates it twice: once on In_Data for seeding, once on Expect for the free-running prediction.

## Test plan
- Acquire lock: reset, then valid 0,5,10,20 on consecutive cycles → Locked = 1 the cycle after 20; Error never asserted; Err_Count = 0.
- Single error: locked, then 13, 7 (26 expected), 17 → one Error pulse after 7; Err_Count = 1; Locked stays 1; 17 matches.
- Lock loss: locked, then four wrong words → four Error pulses, Err_Count = 4, Locked falls after the fourth. The next valid 0 reseeds, and 5,10,20 relock.
- SYNC reseed: 0,5,7,14,28,… → 7 reseeds with no Error and Err_Count unchanged. Lock is declared after three matches following 7.
- Valid gaps: 0,5,10,20 with random-data idle cycles between them → Locked rises the cycle after 20, identical to the gap-free case.
- Saturation and reset: CntWidth = 2, repeated lock/loss cycles → Err_Count stops at 3. Asserting Reset mid-lock → Locked, Error and Err_Count go to 0 immediately.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR pattern generator / checker pair:
// tap masks, checker state encoding and the common next-state function.
package lfsr_pkg;

  localparam int LFSR_MAX_W = 32;

  // Tap masks, one per supported word width; the top bit is never used.
  localparam logic [4:0] TAP5 = 5'b10010;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  // Next LFSR word for a 'width'-bit register held in the low bits of s.
  // The zero-detect term folds the all-zero word into the cycle, so the
  // sequence visits every one of the 2**width values.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_nxt(
    input logic [LFSR_MAX_W-1:0] s,
    input logic [LFSR_MAX_W-1:0] taps,
    input int                    width
  );
    logic [LFSR_MAX_W-1:0] r;
    logic                  z;
    logic                  msb;
    logic                  f;
    r   = {LFSR_MAX_W{1'b0}};
    z   = 1'b1;
    msb = 1'b0;
    for (int i = 0; i < LFSR_MAX_W; i++) begin
      if ((i < width - 1) && s[i]) begin
        z = 1'b0;
      end else begin
        z = z;
      end
      if (i == width - 1) begin
        msb = s[i];
      end else begin
        msb = msb;
      end
    end
    f    = msb ^ z;
    r[0] = f;
    for (int n = 1; n < LFSR_MAX_W; n++) begin
      if (n < width) begin
        r[n] = s[n-1] ^ (taps[n-1] & f);
      end else begin
        r[n] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational LFSR successor: next_state = nxt(state) for a given width
// and tap mask. Width must stay below LFSR_MAX_W.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int               Width = 5,
  parameter logic [Width-1:0] Taps  = TAP5
) (
  input  logic [Width-1:0] state,
  output logic [Width-1:0] next_state
);

  logic [LFSR_MAX_W-1:0] wide_next_s;
  logic                  unused_hi_s;

  assign wide_next_s = lfsr_nxt(LFSR_MAX_W'(state), LFSR_MAX_W'(Taps), Width);
  assign next_state  = wide_next_s[Width-1:0];
  // Upper bits are always zero; folded here only so they are consumed.
  assign unused_hi_s = ^wide_next_s[LFSR_MAX_W-1:Width];

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: hunts for the sequence, locks after SyncCount
// consecutive correct predictions, then free-runs and counts mismatches.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int               Width     = 5,
  parameter logic [Width-1:0] Taps      = TAP5,
  parameter int               SyncCount = 3,
  parameter int               LossCount = 4,
  parameter int               CntWidth  = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                In_Valid,
  input  logic [Width-1:0]    In_Data,
  output logic                Locked,
  output logic                Error,
  output logic [CntWidth-1:0] Err_Count
);

  localparam int MW = $clog2(SyncCount + 1);
  localparam int LW = $clog2(LossCount + 1);
  localparam logic [MW-1:0] SYNC_LAST = MW'(SyncCount - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LossCount - 1);
  localparam logic [CntWidth-1:0] CNT_MAX = {CntWidth{1'b1}};

  chk_state_e          state_r;
  logic [Width-1:0]    expect_r;
  logic [MW-1:0]       match_cnt_r;
  logic [LW-1:0]       miss_cnt_r;
  logic [CntWidth-1:0] err_count_r;
  logic                locked_r;
  logic                error_r;

  logic [Width-1:0]    seed_next_s;
  logic [Width-1:0]    pred_next_s;
  logic                hit_s;

  // Reseeding follows the received word; locked prediction follows Expect.
  lfsr_next #(.Width(Width), .Taps(Taps)) u_seed (
    .state      (In_Data),
    .next_state (seed_next_s)
  );

  lfsr_next #(.Width(Width), .Taps(Taps)) u_pred (
    .state      (expect_r),
    .next_state (pred_next_s)
  );

  assign hit_s = (In_Data == expect_r);

  // Synchronisation FSM, prediction register, counters and registered flags.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r     <= ST_HUNT;
      expect_r    <= {Width{1'b0}};
      match_cnt_r <= {MW{1'b0}};
      miss_cnt_r  <= {LW{1'b0}};
      err_count_r <= {CntWidth{1'b0}};
      locked_r    <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      error_r <= 1'b0;
      if (In_Valid) begin
        case (state_r)
          ST_HUNT: begin
            expect_r    <= seed_next_s;
            match_cnt_r <= {MW{1'b0}};
            state_r     <= ST_SYNC;
            locked_r    <= 1'b0;
          end
          ST_SYNC: begin
            expect_r <= seed_next_s;
            if (hit_s) begin
              match_cnt_r <= match_cnt_r + MW'(1);
              if (match_cnt_r == SYNC_LAST) begin
                state_r    <= ST_LOCKED;
                locked_r   <= 1'b1;
                miss_cnt_r <= {LW{1'b0}};
              end else begin
                state_r  <= ST_SYNC;
                locked_r <= 1'b0;
              end
            end else begin
              match_cnt_r <= {MW{1'b0}};
              state_r     <= ST_SYNC;
              locked_r    <= 1'b0;
            end
          end
          ST_LOCKED: begin
            expect_r <= pred_next_s;
            if (hit_s) begin
              miss_cnt_r <= {LW{1'b0}};
              locked_r   <= 1'b1;
            end else begin
              error_r    <= 1'b1;
              miss_cnt_r <= miss_cnt_r + LW'(1);
              if (err_count_r != CNT_MAX) begin
                err_count_r <= err_count_r + CntWidth'(1);
              end else begin
                err_count_r <= err_count_r;
              end
              if (miss_cnt_r == LOSS_LAST) begin
                state_r  <= ST_HUNT;
                locked_r <= 1'b0;
              end else begin
                state_r  <= ST_LOCKED;
                locked_r <= 1'b1;
              end
            end
          end
          default: begin
            state_r  <= ST_HUNT;
            locked_r <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign Locked    = locked_r;
  assign Error     = error_r;
  assign Err_Count = err_count_r;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: directed scenarios plus a random
// soak, compared every cycle against a table-driven reference model.
module tb_lfsr_checker;

  localparam logic [4:0] TAPS   = 5'b10010;
  localparam int         SYNC_N = 3;
  localparam int         LOSS_N = 4;
  localparam int         HUNTING = 0, SYNCING = 1, LOCKED = 2;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       In_Valid = 1'b0;
  logic [4:0] In_Data = 5'd0;
  logic       locked_a, error_a, locked_b, error_b;
  logic [7:0] err_count_a;
  logic [1:0] err_count_b;

  int n_tests = 0;
  int n_fail  = 0;

  int seq [32];
  int idx_of [32];

  int m_state, m_exp, m_match, m_miss, m_cnt;
  bit m_err, m_locked;
  int tx;

  lfsr_checker #(.Width(5), .Taps(5'b10010), .SyncCount(3), .LossCount(4), .CntWidth(8)) dut (
    .Clock(Clock), .Reset(Reset), .In_Valid(In_Valid), .In_Data(In_Data),
    .Locked(locked_a), .Error(error_a), .Err_Count(err_count_a));

  lfsr_checker #(.Width(5), .Taps(5'b10010), .SyncCount(3), .LossCount(4), .CntWidth(2)) dut_sat (
    .Clock(Clock), .Reset(Reset), .In_Valid(In_Valid), .In_Data(In_Data),
    .Locked(locked_b), .Error(error_b), .Err_Count(err_count_b));

  always #5 Clock = ~Clock;

  function automatic logic [4:0] tb_nxt(logic [4:0] s);
    logic f;
    f = s[4] ^ (s[3:0] == 4'd0);
    return {s[3:0], f} ^ ({TAPS[3:0], 1'b0} & {5{f}});
  endfunction

  function automatic int succ(int w);
    return seq[(idx_of[w] + 1) % 32];
  endfunction

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = HUNTING; m_exp = 0; m_match = 0; m_miss = 0;
    m_cnt = 0; m_err = 1'b0; m_locked = 1'b0;
  endtask

  task automatic model_step(bit v, int d);
    m_err = 1'b0;
    if (v) begin
      if (m_state == HUNTING) begin
        m_exp = succ(d); m_match = 0; m_state = SYNCING;
      end else if (m_state == SYNCING) begin
        if (d == m_exp) begin
          m_match++;
          if (m_match == SYNC_N) begin m_state = LOCKED; m_miss = 0; end
        end else begin
          m_match = 0;
        end
        m_exp = succ(d);
      end else begin
        if (d == m_exp) begin
          m_miss = 0;
        end else begin
          m_err = 1'b1; m_cnt++; m_miss++;
          if (m_miss == LOSS_N) m_state = HUNTING;
        end
        m_exp = succ(m_exp);
      end
    end
    m_locked = (m_state == LOCKED);
  endtask

  task automatic check_all();
    check("locked",        locked_a,    m_locked);
    check("error",         error_a,     m_err);
    check("err_count",     err_count_a, min_i(m_cnt, 255));
    check("locked_sat",    locked_b,    m_locked);
    check("error_sat",     error_b,     m_err);
    check("err_count_sat", err_count_b, min_i(m_cnt, 3));
  endtask

  task automatic drive(bit v, int d);
    @(negedge Clock);
    In_Valid = v;
    In_Data  = 5'(d);
    model_step(v, d);
    @(posedge Clock);
    #1;
    check_all();
  endtask

  task automatic lose_lock();
    for (int k = 0; k < LOSS_N; k++) drive(1'b1, m_exp ^ 1);
  endtask

  initial begin
    logic [4:0] s;
    s = 5'd0;
    for (int i = 0; i < 32; i++) begin
      seq[i] = int'(s);
      idx_of[s] = i;
      s = tb_nxt(s);
    end
    model_reset();

    // Reset state
    #1 Reset = 1'b0;
    @(negedge Clock); @(negedge Clock);
    check("reset_locked", locked_a, 0);
    check("reset_error", error_a, 0);
    check("reset_count", err_count_a, 0);
    Reset = 1'b1;

    // Acquire lock
    drive(1'b1, 0); drive(1'b1, 5); drive(1'b1, 10);
    check("acq_not_yet", locked_a, 0);
    drive(1'b1, 20);
    check("acq_locked", locked_a, 1);
    check("acq_count", err_count_a, 0);

    // Single error inside lock
    drive(1'b1, 13); drive(1'b1, 7);
    check("single_err_pulse", error_a, 1);
    check("single_err_count", err_count_a, 1);
    drive(1'b1, 17);
    check("single_err_clear", error_a, 0);
    check("single_err_locked", locked_a, 1);

    // Lock loss, then reseed and relock
    lose_lock();
    check("loss_unlocked", locked_a, 0);
    check("loss_count", err_count_a, 5);
    drive(1'b1, 0); drive(1'b1, 5); drive(1'b1, 10); drive(1'b1, 20);
    check("relock", locked_a, 1);

    // SYNC reseed produces no error
    lose_lock();
    drive(1'b1, 0); drive(1'b1, 5); drive(1'b1, 7);
    check("reseed_no_err", error_a, 0);
    check("reseed_count", err_count_a, 9);
    drive(1'b1, 14); drive(1'b1, 28);
    check("reseed_not_yet", locked_a, 0);
    drive(1'b1, 29);
    check("reseed_locked", locked_a, 1);

    // Idle gaps with random data between valid words
    lose_lock();
    foreach (seq[i]) begin
      if (i < 4) begin
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) drive(1'b0, int'($urandom_range(0, 31)));
        if (i == 3) check("gap_not_yet", locked_a, 0);
        drive(1'b1, seq[i]);
      end
    end
    check("gap_locked", locked_a, 1);
    check("sat_count", err_count_b, 3);

    // Random soak: mostly correct sequence, occasional corruption and gaps
    tx = succ(20);
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) < 8) begin
        if ($urandom_range(0, 9) < 8) drive(1'b1, tx);
        else drive(1'b1, int'($urandom_range(0, 31)));
        tx = succ(tx);
      end else begin
        drive(1'b0, int'($urandom_range(0, 31)));
      end
    end

    // Reset while locked clears everything at once
    for (int c = 0; c < 40 && !m_locked; c++) begin
      drive(1'b1, tx);
      tx = succ(tx);
    end
    check("pre_reset_locked", locked_a, 1);
    @(negedge Clock);
    In_Valid = 1'b0;
    #2 Reset = 1'b0;
    #1;
    model_reset();
    check("midreset_locked", locked_a, 0);
    check("midreset_error", error_a, 0);
    check("midreset_count", err_count_a, 0);
    check("midreset_count_sat", err_count_b, 0);
    @(negedge Clock);
    Reset = 1'b1;
    drive(1'b1, 0); drive(1'b1, 5); drive(1'b1, 10); drive(1'b1, 20);
    check("post_reset_locked", locked_a, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
